// File: rtl/turbo_frame_loader.sv
// Ping-pong frame loader: serial LLR stream into two encoder matrices per bank, one frame presented at a time.
// Optional frame/error counters are enabled with `define TURBO_FRAME_LOADER_COUNT_EN.
module turbo_frame_loader #(
    parameter int BITS            = 16,
    parameter int BITS_PER_SYMBOL = 2,
    parameter int SYMBOLS         = 10
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [BITS-1:0] s_data,
    input  logic            s_last,
    input  logic            frame_done,
    output logic            out_valid,
    output logic            busy,
    output logic            len_err,
`ifdef TURBO_FRAME_LOADER_COUNT_EN
    output logic [15:0]     frame_count,
    output logic [7:0]      err_count,
`endif
    output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] encoder1_data_out,
    output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] encoder2_data_out
);

    localparam int HALF_LEN  = BITS_PER_SYMBOL * SYMBOLS;
    localparam int FRAME_LEN = 2 * HALF_LEN;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_ACTIVE  = 2'd3
    } bank_st_e;

    bank_st_e         st_q [2];
    bank_st_e         st_d [2];
    logic             fill_bank_q, fill_bank_d;
    logic             active_bank_q, active_bank_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic             len_err_q, len_err_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BITS-1:0]  mem_q [2][FRAME_LEN];

    logic accept;
    logic at_last;
    logic close_frm;
    logic short_close;
    logic done;

    assign s_ready     = (st_q[fill_bank_q] == ST_EMPTY) || (st_q[fill_bank_q] == ST_FILLING);
    assign accept      = s_valid && s_ready;
    assign at_last     = (idx_q == LAST_IDX);
    assign close_frm   = accept && (s_last || at_last);
    assign short_close = accept && s_last && !at_last;
    assign done        = frame_done && busy_q;

    always_comb begin
        st_d[0]       = st_q[0];
        st_d[1]       = st_q[1];
        fill_bank_d   = fill_bank_q;
        active_bank_d = active_bank_q;
        idx_d         = idx_q;
        busy_d        = busy_q;
        out_valid_d   = 1'b0;
        len_err_d     = 1'b0;

        if (accept) begin
            idx_d             = idx_q + IDX_W'(1);
            st_d[fill_bank_q] = ST_FILLING;
        end
        if (close_frm) begin
            st_d[fill_bank_q] = ST_FULL;
            fill_bank_d       = ~fill_bank_q;
            idx_d             = '0;
            len_err_d         = (s_last != at_last);
        end
        if (done) begin
            st_d[active_bank_q] = ST_EMPTY;
            busy_d              = 1'b0;
        end
        // Handoff sees this edge's close and release, so a frame is presented one cycle after its last sample.
        // The non-fill bank always holds the older frame, so it wins when both are full.
        if (!busy_d) begin
            if (st_d[~fill_bank_q] == ST_FULL) begin
                st_d[~fill_bank_q] = ST_ACTIVE;
                active_bank_d      = ~fill_bank_q;
                busy_d             = 1'b1;
                out_valid_d        = 1'b1;
            end else if (st_d[fill_bank_q] == ST_FULL) begin
                st_d[fill_bank_q] = ST_ACTIVE;
                active_bank_d     = fill_bank_q;
                busy_d            = 1'b1;
                out_valid_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q[0]       <= ST_EMPTY;
            st_q[1]       <= ST_EMPTY;
            fill_bank_q   <= 1'b0;
            active_bank_q <= 1'b0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            st_q[0]       <= st_d[0];
            st_q[1]       <= st_d[1];
            fill_bank_q   <= fill_bank_d;
            active_bank_q <= active_bank_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            len_err_q     <= len_err_d;
        end
    end

    // A short frame clears the tail of its bank so stale samples never reach the decoder.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j < FRAME_LEN; j++) begin
                    mem_q[b][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int j = 0; j < FRAME_LEN; j++) begin
                if (IDX_W'(j) == idx_q) begin
                    mem_q[fill_bank_q][j] <= s_data;
                end else if (short_close && (IDX_W'(j) > idx_q)) begin
                    mem_q[fill_bank_q][j] <= '0;
                end
            end
        end
    end

    always_comb begin
        encoder1_data_out = '0;
        encoder2_data_out = '0;
        for (int r = 0; r < BITS_PER_SYMBOL; r++) begin
            for (int c = 0; c < SYMBOLS; c++) begin
                encoder1_data_out[r][c] = mem_q[active_bank_q][r*SYMBOLS + c];
                encoder2_data_out[r][c] = mem_q[active_bank_q][HALF_LEN + r*SYMBOLS + c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign len_err   = len_err_q;

`ifdef TURBO_FRAME_LOADER_COUNT_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    // Counters advance on the same edge that raises out_valid / len_err.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (out_valid_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (len_err_d && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign frame_count = frame_cnt_q;
    assign err_count   = err_cnt_q;
`endif

endmodule
